// File: rtl/uart_core.sv
// Full-duplex 8N1 UART core: independent transmitter and receiver, each driven by
// a bit-period counter, with a two-flop synchroniser in front of the receiver.
module uart_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data_in,
  output logic [7:0] rx_data_out,
  input  logic       start,
  output logic       done_tx,
  output logic       tx_active
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_BIT  = CNT_W'(HALF_BIT);

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_DONE  = 3'd4
  } rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t        tx_state_r, tx_state_s;
  logic [CNT_W-1:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]       tx_idx_r, tx_idx_s;
  logic [7:0]       tx_shift_r, tx_shift_s;
  logic             tx_r, tx_s;
  logic             done_tx_r, done_tx_s;
  logic             tx_active_r, tx_active_s;

  // TX state, counters and registered line/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= CNT_ZERO;
      tx_idx_r    <= 3'd0;
      tx_shift_r  <= 8'h00;
      tx_r        <= 1'b1;
      done_tx_r   <= 1'b0;
      tx_active_r <= 1'b0;
    end else begin
      tx_state_r  <= tx_state_s;
      tx_cnt_r    <= tx_cnt_s;
      tx_idx_r    <= tx_idx_s;
      tx_shift_r  <= tx_shift_s;
      tx_r        <= tx_s;
      done_tx_r   <= done_tx_s;
      tx_active_r <= tx_active_s;
    end
  end

  // TX next state; the line value for the upcoming cycle is decided here so tx stays a flop
  always_comb begin
    tx_state_s  = tx_state_r;
    tx_cnt_s    = tx_cnt_r;
    tx_idx_s    = tx_idx_r;
    tx_shift_s  = tx_shift_r;
    tx_s        = 1'b1;
    done_tx_s   = 1'b0;
    tx_active_s = tx_active_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (start) begin
          tx_shift_s  = tx_data_in;
          tx_active_s = 1'b1;
          tx_cnt_s    = CNT_ZERO;
          tx_s        = 1'b0;
          tx_state_s  = TX_START;
        end else begin
          tx_active_s = 1'b0;
          tx_state_s  = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_s   = CNT_ZERO;
          tx_idx_s   = 3'd0;
          tx_s       = tx_shift_r[0];
          tx_state_s = TX_DATA;
        end else begin
          tx_cnt_s   = tx_cnt_r + CNT_ONE;
          tx_s       = 1'b0;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_s   = CNT_ZERO;
          tx_shift_s = {1'b0, tx_shift_r[7:1]};
          if (tx_idx_r == 3'd7) begin
            tx_s       = 1'b1;
            tx_state_s = TX_STOP;
          end else begin
            tx_idx_s   = tx_idx_r + 3'd1;
            tx_s       = tx_shift_r[1];
          end
        end else begin
          tx_cnt_s   = tx_cnt_r + CNT_ONE;
          tx_s       = tx_shift_r[0];
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_s    = CNT_ZERO;
          done_tx_s   = 1'b1;
          tx_active_s = 1'b0;
          tx_state_s  = TX_DONE;
        end else begin
          tx_cnt_s    = tx_cnt_r + CNT_ONE;
        end
      end
      TX_DONE: begin
        tx_active_s = 1'b0;
        tx_state_s  = TX_IDLE;
      end
      default: begin
        tx_cnt_s    = CNT_ZERO;
        tx_active_s = 1'b0;
        tx_state_s  = TX_IDLE;
      end
    endcase
  end

  assign tx        = tx_r;
  assign done_tx   = done_tx_r;
  assign tx_active = tx_active_r;

  // ---------------- receiver ----------------
  logic [1:0]       rx_sync_r;
  logic             rx_line_s;
  rx_state_t        rx_state_r, rx_state_s;
  logic [CNT_W-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]       rx_idx_r, rx_idx_s;
  logic [7:0]       rx_shift_r, rx_shift_s;
  logic [7:0]       rx_data_r, rx_data_s;

  assign rx_line_s = rx_sync_r[1];

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rx};
    end
  end

  // RX state, counters and the registered received byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_idx_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_idx_r   <= rx_idx_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
    end
  end

  // RX next state: centre-align on the start bit, then sample once per bit period
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_idx_s   = rx_idx_r;
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data_r;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = CNT_ZERO;
        if (!rx_line_s) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == MID_BIT) begin
          rx_cnt_s = CNT_ZERO;
          rx_idx_s = 3'd0;
          if (!rx_line_s) begin
            rx_state_s = RX_DATA;
          end else begin
            rx_state_s = RX_IDLE;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_line_s, rx_shift_r[7:1]};
          if (rx_idx_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_idx_s   = rx_idx_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_s   = CNT_ZERO;
          rx_state_s = RX_DONE;
          if (rx_line_s) begin
            rx_data_s = rx_shift_r;
          end else begin
            rx_data_s = rx_data_r;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DONE: begin
        rx_state_s = RX_IDLE;
      end
      default: begin
        rx_cnt_s   = CNT_ZERO;
        rx_state_s = RX_IDLE;
      end
    endcase
  end

  assign rx_data_out = rx_data_r;

endmodule

// File: tb/tb_uart_core.sv
// Randomised loopback and direct-drive bench for uart_core, checked against a
// frame-level model of the 8N1 line format and the last-valid-byte rule.
module tb_uart_core;

  localparam int CLK_FREQ  = 16000000;
  localparam int BAUD_RATE = 1000000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       tx;
  logic [7:0] tx_data_in;
  logic [7:0] rx_data_out;
  logic       start;
  logic       done_tx;
  logic       tx_active;

  logic       loopback;
  logic       rx_drv;
  logic [7:0] exp_rx;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int active_cyc   = 0;

  assign rx = loopback ? tx : rx_drv;

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .tx         (tx),
    .tx_data_in (tx_data_in),
    .rx_data_out(rx_data_out),
    .start      (start),
    .done_tx    (done_tx),
    .tx_active  (tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_tx) done_cnt++;
    if (tx_active) active_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected line level for bit k of a frame carrying b (0 = start, 9 = stop)
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Send one byte in loopback; optionally try to start a second frame mid-flight
  task automatic send_frame(input logic [7:0] b, input int gap, input bit busy_poke);
    int  cyc;
    int  d0;
    int  a0;
    bit  seen;
    repeat (gap) @(negedge clk);
    d0 = done_cnt;
    a0 = active_cyc;
    tx_data_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_data_in = 8'($urandom);
    cyc = 0;
    check_eq("tx_start_bit", tx, 1'b0);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clk);
      cyc += (k == 0) ? CPB / 2 : CPB;
      check_eq($sformatf("tx_bit%0d_%02h", k, b), tx, frame_bit(b, k));
      if (busy_poke && k == 3) begin
        start = 1'b1;
        tx_data_in = ~b;
      end
      if (busy_poke && k == 4) start = 1'b0;
    end
    seen = 1'b0;
    while (!seen && cyc < 11 * CPB) begin
      @(negedge clk);
      cyc++;
      seen = done_tx;
    end
    check_eq("done_seen", seen, 1'b1);
    check_eq("frame_len", cyc, 10 * CPB);
    exp_rx = b;
    check_eq($sformatf("rx_at_done_%02h", b), rx_data_out, exp_rx);
    repeat (busy_poke ? 3 * CPB : 2) @(negedge clk);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("active_cycles", active_cyc - a0, 10 * CPB);
    if (busy_poke) check_eq("idle_after_busy", {tx_active, tx}, 2'b01);
  endtask

  // Drive a frame straight onto rx with a chosen stop-bit level
  task automatic drive_frame(input logic [7:0] b, input logic stop_lvl);
    for (int k = 0; k < 10; k++) begin
      rx_drv = (k == 9) ? stop_lvl : frame_bit(b, k);
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (stop_lvl) exp_rx = b;
    check_eq($sformatf("rx_direct_%02h_stop%0d", b, stop_lvl), rx_data_out, exp_rx);
  endtask

  initial begin
    int d0;
    rst = 1'b0;
    start = 1'b0;
    tx_data_in = 8'h00;
    loopback = 1'b1;
    rx_drv = 1'b1;
    exp_rx = 8'h00;

    repeat (5) @(negedge clk);
    check_eq("rst_tx_held", tx, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_active", tx_active, 1'b0);
    check_eq("rst_done", done_tx, 1'b0);
    check_eq("rst_rx_data", rx_data_out, exp_rx);

    send_frame(8'hA5, 2, 1'b0);
    send_frame(8'h00, 1, 1'b0);
    send_frame(8'hFF, 0, 1'b0);
    send_frame(8'h3C, 3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 20), 1'b0);
    end

    loopback = 1'b0;
    repeat (4) @(negedge clk);
    drive_frame(8'h5A, 1'b1);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("rx_glitch", rx_data_out, exp_rx);
    drive_frame(8'h77, 1'b0);
    drive_frame(8'h96, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    loopback = 1'b1;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    tx_data_in = 8'h81;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_rx = 8'h00;
    check_eq("midrst_tx", tx, 1'b1);
    check_eq("midrst_active", tx_active, 1'b0);
    check_eq("midrst_done", done_tx, 1'b0);
    check_eq("midrst_rx_data", rx_data_out, exp_rx);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    check_eq("midrst_rx_hold", rx_data_out, exp_rx);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Full-duplex 8N1 UART: 1 start bit, 8 data bits sent LSB first, 1 stop bit, no parity. The transmitter serialises a parallel byte when pulsed by `start`. The receiver deserialises `rx` and presents the byte on `rx_data_out`. The block sits between a host register interface and the board serial pins. In the system bench, `tx` is looped back to `rx`.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 19200, serial bit rate in baud.
- Derived localparam CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer-truncated; 2604 at the defaults.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input; idle high.
- tx  out  1  serial output; idle high.
- tx_data_in  in  8  byte to transmit; sampled in the cycle `start` is high.
- rx_data_out  out  8  last correctly received byte.
- start  in  1  transmit request; level is sampled while the TX FSM is in TX_IDLE.
- done_tx  out  1  one-cycle pulse when a frame's stop bit has completed.
- tx_active  out  1  high while a frame is on the line.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, done_tx=0, tx_active=0, rx_data_out=8'h00.
  - Both FSMs go to IDLE; all counters clear.
  - Reset mid-frame aborts the frame immediately; no done_tx is issued and rx_data_out is not updated.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE.
  - TX_IDLE: tx=1. If start=1, latch tx_data_in into a shift register, set tx_active=1, go to TX_START next cycle.
  - TX_START: tx=0 for CLKS_PER_BIT cycles.
  - TX_DATA: tx = bit[i] for CLKS_PER_BIT cycles each, i=0..7 (LSB first).
  - TX_STOP: tx=1 for CLKS_PER_BIT cycles.
  - TX_DONE: done_tx=1 for exactly one cycle, tx_active=0, return to TX_IDLE.
  - Frame length: 10*CLKS_PER_BIT cycles from the first cycle of tx=0 to the done_tx pulse.
  - start asserted while not in TX_IDLE is ignored (no queueing). Changes to tx_data_in after the latch have no effect.
  - start held high continuously: a new frame begins in the cycle after TX_DONE.
- RX path:
  - rx passes through a 2-flop synchroniser (set to 1 on reset) before the FSM.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE.
  - RX_IDLE: wait for synchronised rx=0.
  - RX_START: count (CLKS_PER_BIT-1)/2 cycles to the bit centre. If rx is still 0, restart the counter and go to RX_DATA. If rx is 1, treat it as a glitch and return to RX_IDLE.
  - RX_DATA: sample at each bit centre (every CLKS_PER_BIT cycles) into bit[i], i=0..7.
  - RX_STOP: at the stop-bit centre, if rx=1, load rx_data_out with the assembled byte. If rx=0 (framing error), discard the byte and leave rx_data_out unchanged.
  - RX_DONE: one cycle, then back to RX_IDLE.
- rx_data_out holds its value until the next valid frame.
- In loopback, rx_data_out is updated at the stop-bit centre, about CLKS_PER_BIT/2 cycles before done_tx. rx_data_out is therefore valid when done_tx pulses.
- TX and RX are fully independent. Simultaneous transmit and receive is legal.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release → tx=1, tx_active=0, done_tx=0, rx_data_out=8'h00.
- Loopback 0xA5 (tx wired to rx): pulse start for 1 cycle with tx_data_in=8'hA5 → tx_active high for 26040 cycles; line pattern 0,1,0,1,0,0,1,0,1,1; exactly one done_tx pulse; rx_data_out=8'hA5 at done_tx.
- Loopback 8'h00 then 8'hFF back-to-back → rx_data_out equals 8'h00, then 8'hFF; two done_tx pulses.
- Busy rejection: start with 8'h3C, then pulse start with 8'hC3 mid-frame → only 8'h3C is transmitted and received; a single done_tx pulse.
- RX glitch: drive rx low for 100 cycles, then high → no data update; RX returns to idle.
- Framing error: drive a frame on rx with stop bit=0 → rx_data_out unchanged. Reset mid-TX-frame → tx=1 immediately, no done_tx pulse.
- Random: 10 random bytes in loopback → every rx_data_out matches the sent byte.
